// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - data RAM with valid/ready request/response handshake, wait states and reset sweep
module data_memory_hs #(
  parameter int N              = 32,
  parameter int BYTES          = 256,
  parameter int WAIT           = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  logic           i_req_we,
  input  logic [31:0]    i_req_addr,
  input  logic [N-1:0]   i_req_wdata,
  input  logic [N/8-1:0] i_req_wstrb,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic [N-1:0]   o_rsp_rdata,
  output logic           o_rsp_err,
  output logic           o_clearing
);

  localparam int B     = N / 8;
  localparam int WORDS = BYTES / B;
  localparam int OFF   = $clog2(B);
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  // WAIT cycles spent in S_WAIT means the countdown starts at WAIT-1 and exits on zero
  localparam logic [3:0] WLOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic [3:0]    wcnt_q;
  logic [N-1:0]  mem [WORDS];
  logic [N-1:0]  rdata_q;
  logic          err_q;
  logic          accept;
  logic          addr_err;
  logic          mem_we;
  logic [AW-1:0] widx;

  assign accept   = (state_q == S_IDLE) && i_req_valid;
  assign addr_err = (i_req_addr[OFF-1:0] != '0) || (i_req_addr >= 32'(BYTES));
  assign widx     = i_req_addr[OFF +: AW];
  // Reset gating keeps a master driving during reset (sweep disabled) from touching the array
  assign mem_we   = accept && i_req_we && !addr_err && i_arst_n;

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_clearing  = (state_q == S_CLEAR);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

  // State register; reset restarts the sweep (or goes straight to idle without it)
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode for sweep, accept, wait countdown and response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (cnt_q == AW'(WORDS - 1)) state_d = S_IDLE;
      S_IDLE:  if (accept) state_d = (WAIT > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wcnt_q == '0) state_d = S_RESP;
      S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep word pointer and wait-state countdown
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt_q  <= '0;
      wcnt_q <= '0;
    end else begin
      if (state_q == S_CLEAR) cnt_q <= cnt_q + AW'(1);
      if (accept)                  wcnt_q <= WLOAD;
      else if (state_q == S_WAIT)  wcnt_q <= wcnt_q - 4'd1;
    end
  end

  // Response word and error flag are captured at accept and held until the handshake
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= addr_err;
      rdata_q <= (i_req_we || addr_err) ? '0 : mem[widx];
    end
  end

  // Array has no reset term: it is zeroed by the sweep or written lane-wise at accept
  always_ff @(posedge i_clk) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (mem_we) begin
      for (int k = 0; k < B; k++) begin
        if (i_req_wstrb[k]) mem[widx][8*k +: 8] <= i_req_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: doc/data_memory_hs.md
# data_memory_hs

Parametrised data RAM with a valid/ready request/response handshake, configurable wait states, error reporting for misaligned and out-of-range accesses, and an optional post-reset zeroing sweep. It sits behind the LSU in the MEM stage. It replaces the single-cycle combinational-read RAM so the core can model slower memory and stall on it. The LSU still performs byte/half selection, sign extension and write-lane alignment; this block sees word-aligned accesses with byte strobes.

## Interface
- N, 32: data width in bits; legal values 32 or 64; B = N/8 bytes per word.
- BYTES, 256: capacity in bytes; power of two and a multiple of B; WORDS = BYTES/B.
- WAIT, 0: extra cycles between request accept and response; legal range 0..15.
- CLEAR_ON_RESET, 1: 1 means zero every word after reset via a sweep; 0 means contents are undefined at power-up and preserved across reset.

- i_clk, input, 1: clock; all state updates on the rising edge.
- i_arst_n, input, 1: reset; asynchronous, active-low.
- i_req_valid, input, 1: request present.
- o_req_ready, output, 1: block can accept a request.
- i_req_we, input, 1: 1 = write, 0 = read.
- i_req_addr, input, 32: byte address.
- i_req_wdata, input, N: write data, little-endian lanes.
- i_req_wstrb, input, B: byte enables; bit k writes lane k.
- o_rsp_valid, output, 1: response present.
- i_rsp_ready, input, 1: consumer accepts the response.
- o_rsp_rdata, output, N: raw read word; 0 for writes and errors.
- o_rsp_err, output, 1: 1 when the request was misaligned or out of range.
- o_clearing, output, 1: zeroing sweep in progress.

## Operation
- Accept occurs on a rising edge with i_req_valid=1 and o_req_ready=1. Only one transaction is outstanding at a time.
- Error check at accept:
  - err = (i_req_addr[log2(B)-1:0] != 0) OR (i_req_addr >= BYTES).
  - An erroring request never modifies the memory.
  - It returns rdata = 0 and err = 1.
- Write without error: at the accept edge, lane k of word i_req_addr/B takes wdata lane k where wstrb[k]=1. wstrb = 0 is a legal no-op and still gets a response with err = 0.
- Read without error: the word is captured into the response register at the accept edge.
- FSM states: CLEAR, IDLE, WAIT, RESP.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - CLEAR: writes 0 to word cnt each cycle for cnt = 0..WORDS-1, then goes to IDLE. o_clearing=1 and o_req_ready=0 throughout.
  - IDLE: o_req_ready=1. On accept, go to WAIT (loading wcnt = WAIT-1) if WAIT>0, else go to RESP.
  - WAIT: wcnt decrements each cycle; when wcnt = 0, go to RESP.
  - RESP: o_rsp_valid=1 and o_req_ready=0. rdata and err stay stable until i_rsp_ready=1, then return to IDLE.
- In RESP, i_req_valid is ignored; the next request can be accepted only in IDLE.
- Requests presented while not ready must be held by the master; there is no internal queue.
- Async reset mid-transaction aborts it; no response is ever issued for it.
  - A write already past its accept edge stays committed.
  - With CLEAR_ON_RESET=1 the sweep restarts from word 0.
  - The memory array itself has no reset term.

## Timing
- Reset values:
  - o_req_ready = 0 (CLEAR) or 1 (IDLE, when CLEAR_ON_RESET=0).
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - o_clearing = CLEAR_ON_RESET.
- Sweep length: exactly WORDS cycles after reset deassertion; o_req_ready rises in cycle WORDS.
- Accept at edge k puts o_rsp_valid high from cycle k+1+WAIT.
- Minimum request-to-request spacing is WAIT+2 cycles, achieved when i_rsp_ready is held 1.
- o_rsp_valid drops in the cycle after the response handshake edge; o_req_ready rises in that same cycle.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Test plan
- Sweep (N=32, BYTES=256, CLEAR_ON_RESET=1):
  - Release reset. Expect o_clearing=1 for exactly 64 cycles, then o_req_ready=1.
  - Then read 0xFC. Expect rdata=0x00000000, err=0.
- Strobes:
  - Write 0x10 with 0xAABBCCDD, wstrb=0xF.
  - Then write 0x10 with 0x11223344, wstrb=0x5.
  - Then read 0x10. Expect 0xAA22CC44.
- Errors:
  - Read 0x12. Expect err=1, rdata=0.
  - Write 0x100 with 0xFFFFFFFF, wstrb=0xF. Expect err=1, and memory unchanged (read 0x00 returns its prior value).
- Latency/backpressure (WAIT=3):
  - Accept at edge k. Expect o_rsp_valid rising in cycle k+4.
  - Hold i_rsp_ready=0 for 5 cycles. Expect valid, rdata and err stable and o_req_ready=0 throughout.
- 64-bit:
  - N=64: write 0x08 with 0x0123456789ABCDEF, wstrb=0xF0.
  - Then read 0x08. Expect 0x0123456700000000 after sweep.
  - Then read 0x04. Expect err=1.
- Reset mid-WAIT:
  - Assert i_arst_n=0 during WAIT after a read accept. Expect no response.
  - Expect o_rsp_valid=0 immediately (asynchronously).
  - Expect the sweep to restart, taking 64 cycles.
